// File: rtl/edge_raster_out_if.sv
// rtl/edge_raster_out_if.sv - input pixel stream and output raster stream of edge_raster_out
interface edge_raster_out_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   in_valid;
    logic [PIXEL_WIDTH-1:0] in_pixel;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic                   out_sof;
    logic                   out_eol;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_sof, out_eol
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_sof, out_eol
    );
endinterface

// File: rtl/edge_raster_out.sv
// rtl/edge_raster_out.sv - re-frames interior Sobel pixels into a full raster with constant border
// Optional statistics ports (frame_count, stall_count) enabled by EDGE_RASTER_STATS_EN.
module edge_raster_out #(
    parameter int                     IMG_WIDTH    = 640,
    parameter int                     IMG_HEIGHT   = 480,
    parameter int                     PIXEL_WIDTH  = 8,
    parameter int                     ADDR_WIDTH   = 10,
    parameter int                     FIFO_DEPTH   = 16,
    parameter logic [PIXEL_WIDTH-1:0] BORDER_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    edge_raster_out_if.slave   bus,
`ifdef EDGE_RASTER_STATS_EN
    output logic [15:0]        frame_count,
    output logic [15:0]        stall_count,
`endif
    output logic               busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  col_q, col_d, row_q, row_d;
    logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   out_valid_q, out_valid_d;
    logic [PIXEL_WIDTH-1:0] out_pixel_q, out_pixel_d;
    logic                   out_sof_q, out_sof_d;
    logic                   out_eol_q, out_eol_d;
    logic                   busy_q, busy_d;
    logic                   wr_en, rd_en, load_ok, fifo_empty, at_border, in_ready;
`ifdef EDGE_RASTER_STATS_EN
    logic                   last_q, last_d;
    logic [15:0]            frame_count_q, frame_count_d, stall_count_q, stall_count_d;
`endif

    // in_ready depends only on the registered fill level, never on out_ready
    assign in_ready   = (count_q != FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign wr_en      = bus.in_valid && in_ready;
    assign load_ok    = !out_valid_q || bus.out_ready;
    assign at_border  = (row_q == '0) || (row_q == ROW_LAST) ||
                        (col_q == '0) || (col_q == COL_LAST);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        rd_en       = 1'b0;
`ifdef EDGE_RASTER_STATS_EN
        last_d        = last_q;
        stall_count_d = stall_count_q;
        frame_count_d = frame_count_q;
        if (out_valid_q && bus.out_ready && last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    if (!fifo_empty) begin
                        // (0,0) is always border, so it is emitted straight from IDLE
                        out_valid_d = 1'b1;
                        out_pixel_d = BORDER_VALUE;
                        out_sof_d   = 1'b1;
                        out_eol_d   = 1'b0;
                        col_d       = ADDR_WIDTH'(1);
                        row_d       = '0;
                        state_d     = RUN;
`ifdef EDGE_RASTER_STATS_EN
                        last_d        = 1'b0;
                        stall_count_d = '0;
`endif
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            RUN: begin
`ifdef EDGE_RASTER_STATS_EN
                if (!at_border && fifo_empty && stall_count_q != 16'hFFFF) begin
                    stall_count_d = stall_count_q + 16'd1;
                end
`endif
                if (load_ok) begin
                    if (at_border || !fifo_empty) begin
                        out_valid_d = 1'b1;
                        out_pixel_d = at_border ? BORDER_VALUE : mem_q[rd_ptr_q];
                        rd_en       = !at_border;
                        out_sof_d   = 1'b0;
                        out_eol_d   = (col_q == COL_LAST);
`ifdef EDGE_RASTER_STATS_EN
                        last_d      = (col_q == COL_LAST) && (row_q == ROW_LAST);
`endif
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                state_d = IDLE;
                            end else begin
                                row_d = row_q + ADDR_WIDTH'(1);
                            end
                        end else begin
                            col_d = col_q + ADDR_WIDTH'(1);
                        end
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d == RUN);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_pixel_q   <= '0;
            out_sof_q     <= 1'b0;
            out_eol_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef EDGE_RASTER_STATS_EN
            last_q        <= 1'b0;
            frame_count_q <= '0;
            stall_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_pixel_q   <= out_pixel_d;
            out_sof_q     <= out_sof_d;
            out_eol_q     <= out_eol_d;
            busy_q        <= busy_d;
`ifdef EDGE_RASTER_STATS_EN
            last_q        <= last_d;
            frame_count_q <= frame_count_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eol   = out_eol_q;
    assign busy          = busy_q;
`ifdef EDGE_RASTER_STATS_EN
    assign frame_count   = frame_count_q;
    assign stall_count   = stall_count_q;
`endif
endmodule

// File: tb/tb_edge_raster_out.sv
// tb/tb_edge_raster_out.sv - scoreboard bench for edge_raster_out on a 5x4 frame
module tb_edge_raster_out;
    localparam int W = 5, H = 4, PW = 8, AW = 10, FD = 16;

    typedef struct {
        logic [PW-1:0] px;
        logic          sof;
        logic          eol;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef EDGE_RASTER_STATS_EN
    logic [15:0] frame_count, stall_count;
`endif

    edge_raster_out_if #(.PIXEL_WIDTH(PW)) bus();

    edge_raster_out #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW),
        .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .BORDER_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
`ifdef EDGE_RASTER_STATS_EN
        .frame_count(frame_count),
        .stall_count(stall_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int n_checks = 0, n_pass = 0;
    int ready_mode = 0;
    int n_acc = 0;
    int cyc = 0;
    int first_t = -1, last_t = -1;
    int frames_seen = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] held_px;
    logic          held_sof, held_eol;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_frame(input logic [PW-1:0] base);
        exp_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H-1 || c == 0 || c == W-1) e.px = 8'h00;
                else e.px = base + PW'((r-1)*(W-2) + (c-1));
                e.sof  = (r == 0 && c == 0);
                e.eol  = (c == W-1);
                e.last = (r == H-1 && c == W-1);
                q.push_back(e);
            end
        end
    endtask

    task automatic push_px(input logic [PW-1:0] p);
        int  t = 0;
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        forever begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 300) begin
                check_val("push_timeout", 32'(1), 32'(0));
                break;
            end
        end
        if (acc) n_acc++;
        bus.in_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [PW-1:0] base);
        for (int i = 0; i < (W-2)*(H-2); i++) push_px(base + PW'(i));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check_val("drain_done", 32'(q.size() == 0), 32'(1));
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_busy", 32'(busy), 32'(0));
        check_val("idle_valid", 32'(bus.out_valid), 32'(0));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", 32'(bus.out_valid), 32'(1));
                check_val("hold_px", 32'(bus.out_pixel), 32'(held_px));
                check_val("hold_flags", 32'({bus.out_sof, bus.out_eol}), 32'({held_sof, held_eol}));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check_val("unexpected_out", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    check_val("px", 32'(bus.out_pixel), 32'(e.px));
                    check_val("sof", 32'(bus.out_sof), 32'(e.sof));
                    check_val("eol", 32'(bus.out_eol), 32'(e.eol));
                    if (e.last) frames_seen++;
                    if (first_t < 0) first_t = cyc;
                    last_t = cyc;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_px    = bus.out_pixel;
            held_sof   = bus.out_sof;
            held_eol   = bus.out_eol;
        end
    end

    initial begin
        #500000;
        check_val("watchdog", 32'(0), 32'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        int t;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(bus.out_valid), 32'(0));
        check_val("rst_px", 32'(bus.out_pixel), 32'(0));
        check_val("rst_sof", 32'(bus.out_sof), 32'(0));
        check_val("rst_eol", 32'(bus.out_eol), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_in_ready", 32'(bus.in_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic frame with first-pixel latency
        expect_frame(8'h11);
        push_px(8'h11);
        check_val("lat_early", 32'(bus.out_valid), 32'(0));
        push_px(8'h12);
        check_val("lat_valid", 32'(bus.out_valid), 32'(1));
        check_val("lat_sof", 32'(bus.out_sof), 32'(1));
        check_val("run_busy", 32'(busy), 32'(1));
        for (int i = 2; i < 6; i++) push_px(8'h11 + PW'(i));
        wait_drain();

        // toggling backpressure
        ready_mode = 1;
        expect_frame(8'h11);
        push_frame(8'h11);
        wait_drain();
        ready_mode = 0;

        // fill FIFO under full backpressure
        ready_mode = 2;
        @(posedge clk);
        #1;
        n_acc = 0;
        expect_frame(8'h20);
        expect_frame(8'h26);
        expect_frame(8'h2C);
        fork
            begin
                push_frame(8'h20);
                push_frame(8'h26);
                push_frame(8'h2C);
            end
            begin
                t = 0;
                while (bus.in_ready && t < 200) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                check_val("full_accepts", 32'(n_acc), 32'(FD));
                check_val("full_in_ready", 32'(bus.in_ready), 32'(0));
                repeat (5) @(posedge clk);
                #2;
                check_val("full_no_more", 32'(n_acc), 32'(FD));
                ready_mode = 0;
            end
        join
        wait_drain();

        // input gap stalls at first interior of row 2
        expect_frame(8'h40);
        for (int i = 0; i < 3; i++) push_px(8'h40 + PW'(i));
        repeat (20) @(posedge clk);
        #1;
        check_val("gap_valid", 32'(bus.out_valid), 32'(0));
        check_val("gap_busy", 32'(busy), 32'(1));
`ifdef EDGE_RASTER_STATS_EN
        check_val("gap_stall_nz", 32'(stall_count != 16'd0), 32'(1));
`endif
        for (int i = 3; i < 6; i++) push_px(8'h40 + PW'(i));
        wait_drain();

        // asynchronous reset mid-frame
        expect_frame(8'h50);
        push_frame(8'h50);
        t = 0;
        while (q.size() > W*H - 8 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("mid_reached", 32'(q.size() <= W*H - 8), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(bus.out_valid), 32'(0));
        check_val("arst_px", 32'(bus.out_pixel), 32'(0));
        check_val("arst_flags", 32'({bus.out_sof, bus.out_eol}), 32'(0));
        check_val("arst_busy", 32'(busy), 32'(0));
        check_val("arst_in_ready", 32'(bus.in_ready), 32'(1));
        q.delete();
        frames_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_frame(8'h11);
        push_frame(8'h11);
        wait_drain();

        // two back-to-back frames
        first_t = -1;
        expect_frame(8'h60);
        expect_frame(8'h66);
        push_frame(8'h60);
        push_frame(8'h66);
        wait_drain();
        check_val("b2b_span", 32'(last_t - first_t), 32'(2*W*H - 1));
`ifdef EDGE_RASTER_STATS_EN
        check_val("frame_count", 32'(frame_count), 32'(frames_seen));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
